fcmp_lt_scheduler: RTL
======================

// Module: fcmp_lt_scheduler
// PURPOSE
//   Shares one pipelined single-precision float less-than comparator (external core, fixed latency LAT)
//   between N requesters. Round-robin arbitration issues at most one compare per enabled cycle.
//   A tag pipeline tracks each in-flight compare, so every result returns to the requester that issued it.
//   Sits between the generated datapath operators and the single comparator instance.
// PARAMETERS
//   N      4   number of requesters, 2..16; tag width TW = clog2(N)
//   LAT    2   comparator latency, 1..8: cycles from cmp_a/cmp_b presented to cmp_result valid
//   DW     32  operand width (IEEE-754 single)
// PORTS
//   clk         in   1     clock, rising edge
//   rst_n       in   1     asynchronous active-low reset
//   ce          in   1     global clock enable; low = whole block and comparator stall
//   req_valid   in   N     requester i has a compare pending
//   req_a       in   N*DW  operand a of requester i = req_a[i*DW +: DW]
//   req_b       in   N*DW  operand b of requester i, same packing
//   req_ready   out  N     one-hot grant; transfer when req_valid[i] & req_ready[i]
//   rsp_valid   out  N     one-cycle pulse: result for requester i
//   rsp_result  out  1     a < b for the pulsing requester
//   busy        out  1     any compare in flight
//   cmp_ce      out  1     comparator clock enable (= ce)
//   cmp_a       out  DW    registered operand a to comparator
//   cmp_b       out  DW    registered operand b to comparator
//   cmp_result  in   1     comparator result bit
// BEHAVIOUR
//   Reset (async, rst_n=0)
//   - cmp_a, cmp_b: 0. All tag stages invalid. RR pointer last = N-1, so requester 0 has priority first.
//   - rsp_valid: 0. rsp_result: 0. busy: 0. req_ready: 0 while rst_n=0.
//   Arbitration (combinational)
//   - Search for the first i with req_valid[i], starting at last+1 and wrapping mod N.
//   - req_ready[i] = ce & (i == winner); all zero if there are no requests or ce=0.
//   - At a clock edge with a transfer: last <= winner; otherwise last holds.
//   - req_ready does not depend on req_ready of other requesters. There is no back-pressure from the comparator.
//   Issue (edge E0 with transfer)
//   - cmp_a/cmp_b <= winner's operands. tag_v[0] <= 1, tag_id[0] <= winner.
//   - At an enabled edge with no transfer: tag_v[0] <= 0; cmp_a/cmp_b hold.
//   Tag pipeline
//   - Stages 0..LAT. At every edge with ce=1, stage k+1 <= stage k.
//   - With ce=0, all stages, cmp_a/cmp_b and last hold.
//   Response
//   - rsp_valid[i] = ce & tag_v[LAT] & (tag_id[LAT] == i).
//   - rsp_result = (ce & tag_v[LAT]) ? cmp_result : 0.
//   - Latency: transfer accepted in cycle T -> rsp_valid in cycle T+LAT+1 (T+3 at LAT=2), counting only ce=1 cycles.
//   - Each request yields exactly one rsp_valid pulse. A ce=0 cycle masks the pulse; it appears on the next ce=1 cycle.
//   Status
//   - busy = OR of tag_v[0..LAT].
//   Boundary cases
//   - Back-to-back issue: one compare per cycle; LAT+1 compares may be in flight.
//   - Same requester may issue again while its earlier compare is in flight; responses return in issue order.
//   - Requester dropping req_valid without ready: no issue, pointer unchanged.
//   - Reset mid-operation: in-flight compares are discarded, no rsp_valid pulses follow. The comparator's own stale
//     output is ignored because all tags are invalid.
//   - N not a power of 2: winner index never exceeds N-1; the wrap is mod N, not mod 2^TW.
// TESTING
//   1 Reset: rst_n=0 with random req_valid -> req_ready=0, rsp_valid=0, busy=0.
//     Release, then req_valid=4'b0001, a=1.0, b=2.0 -> req_ready=0001 in cycle T;
//     rsp_valid=0001, rsp_result=1 at T+3 (LAT=2).
//   2 Fairness: req_valid=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
//     Responses appear in that order from T+3, one per cycle; results match a golden float model.
//   3 Skip/wrap: req_valid=4'b1010, last=1 -> grants 3,1,3,1.
//     Then req_valid=4'b0001 -> grant 0 next cycle.
//   4 Stall: issue to requester 2, force ce=0 for 5 cycles mid-flight -> req_ready=0 and no rsp_valid while ce=0.
//     Exactly one rsp_valid[2] pulse after 3 enabled cycles in total.
//   5 Reset mid-op: 3 compares in flight, pulse rst_n low for 1 cycle -> no rsp_valid afterwards;
//     the next request is granted to requester 0 first.
//   6 Values: a=-0.0, b=+0.0 -> result 0. a=-3.5, b=-1.0 -> result 1. a=+inf, b=1.0 -> result 0.
//     (Values as produced by the comparator; bench compares against a golden model.)

Source files
------------

// File: rtl/fcmp_lt_scheduler_if.sv
// Requester-side bundle of the shared float less-than scheduler: operand
// requests flow in, one-hot grants and one-hot result pulses flow back.
interface fcmp_lt_scheduler_if #(
    parameter int N  = 4,
    parameter int DW = 32
);
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic            rsp_result;

    // Requester side drives operands, scheduler drives grants and results
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/fcmp_lt_scheduler.sv
// Round-robin sharing of one pipelined float less-than comparator between N
// requesters. A tag pipeline of LAT+1 stages follows every issued compare so
// its result is routed back to the requester that issued it.
module fcmp_lt_scheduler #(
    parameter int N   = 4,
    parameter int LAT = 2,
    parameter int DW  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce_i,
    fcmp_lt_scheduler_if.slave req_if,
    output logic               busy_o,
    output logic               cmp_ce_o,
    output logic [DW-1:0]      cmp_a_o,
    output logic [DW-1:0]      cmp_b_o,
    input  logic               cmp_result_i
);
    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0] LAST_RST = TW'(N - 1);

    logic [TW-1:0] last_q, last_d;
    logic [TW-1:0] winner;
    logic          found;
    logic          xfer;
    logic [DW-1:0] cmp_a_q, cmp_a_d;
    logic [DW-1:0] cmp_b_q, cmp_b_d;
    logic          tag_v_d;
    logic [TW-1:0] tag_id_d;
    logic [LAT:0]  tag_v_q;
    logic [TW-1:0] tag_id_q [LAT+1];
    logic          rsp_fire;
    logic [DW-1:0] op_a [N];
    logic [DW-1:0] op_b [N];

    // Unpack the flat operand buses into per-requester words
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign op_a[gi] = req_if.req_a[gi*DW +: DW];
        assign op_b[gi] = req_if.req_b[gi*DW +: DW];
    end

    // Round-robin search starting one past the last winner; wrap is modulo N
    // so a non-power-of-two N never yields an out-of-range winner
    always_comb begin
        logic [TW-1:0] cand;
        cand   = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = TW'((int'(last_q) + k) % N);
            if (!found && req_if.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // A grant is only offered while enabled and out of reset
    assign xfer = ce_i & rst_n & found;

    // One-hot grant to the winner
    always_comb begin
        req_if.req_ready = '0;
        if (xfer) begin
            req_if.req_ready[winner] = 1'b1;
        end
    end

    // Issue decision: capture the winner's operands and tag, else stage 0 goes empty
    always_comb begin
        last_d   = last_q;
        cmp_a_d  = cmp_a_q;
        cmp_b_d  = cmp_b_q;
        tag_v_d  = 1'b0;
        tag_id_d = tag_id_q[0];
        if (xfer) begin
            last_d   = winner;
            cmp_a_d  = op_a[winner];
            cmp_b_d  = op_b[winner];
            tag_v_d  = 1'b1;
            tag_id_d = winner;
        end
    end

    // Pointer, operand registers and tag pipeline all freeze together when ce is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= LAST_RST;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            tag_v_q <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else if (ce_i) begin
            last_q      <= last_d;
            cmp_a_q     <= cmp_a_d;
            cmp_b_q     <= cmp_b_d;
            tag_v_q[0]  <= tag_v_d;
            tag_id_q[0] <= tag_id_d;
            for (int k = 1; k <= LAT; k++) begin
                tag_v_q[k]  <= tag_v_q[k-1];
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    // The last stage lines up with the comparator output; a stalled cycle masks it
    assign rsp_fire = ce_i & tag_v_q[LAT];

    // Route the result pulse back to the issuing requester
    always_comb begin
        req_if.rsp_valid = '0;
        if (rsp_fire) begin
            req_if.rsp_valid[tag_id_q[LAT]] = 1'b1;
        end
    end

    assign req_if.rsp_result = rsp_fire & cmp_result_i;
    assign busy_o            = |tag_v_q;
    assign cmp_ce_o          = ce_i;
    assign cmp_a_o           = cmp_a_q;
    assign cmp_b_o           = cmp_b_q;
endmodule
